// File: rtl/testcase_decode.sv
// Receive-side decoder: undoes the conditional inversion applied upstream and
// buffers the restored words in a small FIFO behind a valid/ready handshake.
package testcase_pkg;
  localparam int SIZE = 8;
  typedef enum logic [1:0] {ENUM0 = 2'd0, ENUM1 = 2'd1, ENUM2 = 2'd2} enum_t;
endpackage

module testcase_decode
  import testcase_pkg::*;
#(
  parameter int SIZE  = testcase_pkg::SIZE,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  enum_t                      in_enum,
  input  logic [SIZE-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            out_data,
  output logic                       out_inv,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_count,
  output logic [CNT_W-1:0]           inv_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SIZE-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0] r_inv;
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_invCount;

  logic             w_push;
  logic             w_pop;
  logic             w_isInv;
  logic [SIZE-1:0]  w_decoded;

  // Ready depends only on occupancy, so a pop never frees room for a same-cycle push.
  assign in_ready  = (r_level != LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_isInv   = (in_enum == ENUM1);
  assign w_decoded = w_isInv ? ~in_data : in_data;

  assign out_data  = r_mem[r_rdPtr];
  assign out_inv   = r_inv[r_rdPtr];
  assign level     = r_level;
  assign inv_count = r_invCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_inv   <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= w_decoded;
        r_inv[r_wrPtr] <= w_isInv;
        r_wrPtr        <= (r_wrPtr == AW'(DEPTH - 1)) ? '0 : r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == AW'(DEPTH - 1)) ? '0 : r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // Saturating count of inverted words; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_invCount <= '0;
    end else if (clr_count) begin
      r_invCount <= '0;
    end else if (w_push && w_isInv && (r_invCount != '1)) begin
      r_invCount <= r_invCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_testcase_decode.sv
// Self-checking bench for testcase_decode: a queue-based reference model is compared
// every cycle against two instances (wide and 2-bit inverted-word counters).
module tb_testcase_decode;
  import testcase_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  enum_t       inEnum;
  logic [7:0]  inData;
  logic        outReady;
  logic        clrCount;

  logic        inReady, outValid, outInv;
  logic [7:0]  outData;
  logic [2:0]  level;
  logic [15:0] invCount;

  logic        sInReady, sOutValid, sOutInv;
  logic [7:0]  sOutData;
  logic [2:0]  sLevel;
  logic [1:0]  sInvCount;

  typedef struct {
    logic [7:0] data;
    logic       inv;
  } entry_t;

  entry_t mq[$];
  int     mCnt16;
  int     mCnt2;
  int     nChecks = 0;
  int     nErrors = 0;

  testcase_decode #(.SIZE(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .in_enum(inEnum), .in_data(inData), .out_valid(outValid), .out_ready(outReady),
    .out_data(outData), .out_inv(outInv), .level(level), .clr_count(clrCount),
    .inv_count(invCount)
  );

  testcase_decode #(.SIZE(8), .DEPTH(DEPTH), .CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(sInReady),
    .in_enum(inEnum), .in_data(inData), .out_valid(sOutValid), .out_ready(outReady),
    .out_data(sOutData), .out_inv(sOutInv), .level(sLevel), .clr_count(clrCount),
    .inv_count(sInvCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input enum_t e, input logic [7:0] d,
                               input logic rdy, input logic clr);
    inValid  = v;
    inEnum   = e;
    inData   = d;
    outReady = rdy;
    clrCount = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of decoded words plus two saturating counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mCnt16 = 0;
      mCnt2  = 0;
    end else begin
      automatic bit doPush = inValid && (mq.size() < DEPTH);
      automatic bit doPop  = (mq.size() > 0) && outReady;
      automatic entry_t e;
      if (doPop) void'(mq.pop_front());
      if (doPush) begin
        e.inv  = (inEnum == ENUM1);
        e.data = e.inv ? ~inData : inData;
        mq.push_back(e);
      end
      if (clrCount) begin
        mCnt16 = 0;
        mCnt2  = 0;
      end else if (doPush && inEnum == ENUM1) begin
        if (mCnt16 < 65535) mCnt16++;
        if (mCnt2 < 3) mCnt2++;
      end
    end
  end

  // Compare both instances against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    checkOutput("in_ready", {31'd0, inReady}, {31'd0, mq.size() != DEPTH});
    checkOutput("out_valid", {31'd0, outValid}, {31'd0, mq.size() != 0});
    checkOutput("level", {29'd0, level}, mq.size());
    checkOutput("inv_count", {16'd0, invCount}, mCnt16);
    checkOutput("s_in_ready", {31'd0, sInReady}, {31'd0, mq.size() != DEPTH});
    checkOutput("s_level", {29'd0, sLevel}, mq.size());
    checkOutput("s_inv_count", {30'd0, sInvCount}, mCnt2);
    if (mq.size() != 0) begin
      checkOutput("out_data", {24'd0, outData}, {24'd0, mq[0].data});
      checkOutput("out_inv", {31'd0, outInv}, {31'd0, mq[0].inv});
      checkOutput("s_out_data", {24'd0, sOutData}, {24'd0, mq[0].data});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    automatic int expCnt2[5] = '{1, 2, 3, 3, 3};
    automatic logic acc;

    rst_n = 1'b0;
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    checkOutput("rst in_ready", {31'd0, inReady}, 32'd1);
    checkOutput("rst out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst level", {29'd0, level}, 32'd0);
    checkOutput("rst inv_count", {16'd0, invCount}, 32'd0);
    checkOutput("rst out_data", {24'd0, outData}, 32'h00);
    checkOutput("rst out_inv", {31'd0, outInv}, 32'd0);

    $display("[TB] basic decode");
    applyStimulus(1'b1, ENUM1, 8'h3C, 1'b1, 1'b0);
    tick();
    checkOutput("t2 out_valid", {31'd0, outValid}, 32'd1);
    checkOutput("t2 out_data", {24'd0, outData}, 32'hC3);
    checkOutput("t2 out_inv", {31'd0, outInv}, 32'd1);
    checkOutput("t2 inv_count", {16'd0, invCount}, 32'd1);
    applyStimulus(1'b1, ENUM2, 8'hA5, 1'b1, 1'b0);
    tick();
    checkOutput("t2 out_data2", {24'd0, outData}, 32'hA5);
    checkOutput("t2 out_inv2", {31'd0, outInv}, 32'd0);
    checkOutput("t2 inv_count2", {16'd0, invCount}, 32'd1);
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b1, 1'b0);
    tick();

    $display("[TB] fill and drain");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, ENUM2, 8'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("t3 in_ready full", {31'd0, inReady}, 32'd0);
    checkOutput("t3 level full", {29'd0, level}, 32'd4);
    applyStimulus(1'b1, ENUM2, 8'h05, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("t3 level held", {29'd0, level}, 32'd4);
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3 drain order", {24'd0, outData}, 32'(i + 1));
      acc = inValid && inReady;
      tick();
      if (acc) inValid = 1'b0;
    end
    checkOutput("t3 level empty", {29'd0, level}, 32'd0);

    $display("[TB] steady push/pop");
    applyStimulus(1'b1, ENUM2, 8'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, ENUM1, 8'h11, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? ENUM2 : ENUM1, 8'(8'h20 + i), 1'b1, 1'b0);
      tick();
      checkOutput("t4 level", {29'd0, level}, 32'd2);
    end
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();

    $display("[TB] counter saturation");
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("t5 cleared", {30'd0, sInvCount}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ENUM1, 8'($urandom), 1'b1, 1'b0);
      tick();
      checkOutput("t5 sat count", {30'd0, sInvCount}, expCnt2[i]);
    end
    applyStimulus(1'b1, ENUM1, 8'h5A, 1'b1, 1'b1);
    tick();
    checkOutput("t5 clr wins", {30'd0, sInvCount}, 32'd0);
    checkOutput("t5 clr wins wide", {16'd0, invCount}, 32'd0);
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ENUM2, 8'(8'h40 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b0, 1'b0);
    checkOutput("t6 level 3", {29'd0, level}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("t6 async level", {29'd0, level}, 32'd0);
    checkOutput("t6 async in_ready", {31'd0, inReady}, 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, ENUM1, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("t6 out_data", {24'd0, outData}, 32'h00);
    checkOutput("t6 out_inv", {31'd0, outInv}, 32'd1);
    checkOutput("t6 level", {29'd0, level}, 32'd1);
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b1, 1'b0);
    tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, enum_t'($urandom_range(0, 2)), 8'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      tick();
    end
    applyStimulus(1'b0, ENUM2, 8'h00, 1'b1, 1'b0);
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/testcase_decode.md
# testcase_decode

Inverse of the conditional-inversion encoding used between the `testcase_sub1` and `testcase_sub2` stages. It accepts encoded words tagged with a `testcase_pkg::enum_t` mode and restores the original data: `ENUM1` words are re-inverted, `ENUM2` words pass unchanged. Decoded words are buffered in a small FIFO behind a valid/ready handshake. The block sits on the receive side of the `testcase_top` datapath and imports `testcase_pkg`.

## Interface

Parameters:
- `SIZE`, default `testcase_pkg::SIZE` (8): data width.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: width of the inverted-word counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  encoded word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_enum`  in  `testcase_pkg::enum_t`  encoding mode of `in_data`.
- `in_data`  in  `[SIZE-1:0]`  encoded word.
- `out_valid`  out  1  decoded word available at FIFO head.
- `out_ready`  in  1  downstream consumes head this cycle.
- `out_data`  out  `[SIZE-1:0]`  decoded word at FIFO head.
- `out_inv`  out  1  head word was received as `ENUM1`.
- `level`  out  `[$clog2(DEPTH):0]`  current FIFO occupancy.
- `clr_count`  in  1  synchronous clear of `inv_count`.
- `inv_count`  out  `[CNT_W-1:0]`  number of accepted `ENUM1` words, saturating.

## Operation

- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Decode is applied at write: the stored value is `~in_data` when `in_enum==ENUM1`, otherwise `in_data`. The stored inversion flag is `in_enum==ENUM1`.
- FIFO storage:
  - Circular buffer with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, plus an occupancy register `level`.
  - Pointers wrap from `DEPTH-1` to 0.
  - `level` changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
- `in_ready = (level != DEPTH)`. It is derived from registered state only and never depends on `out_ready`. A pop does not free space for a push in the same cycle.
- `out_valid = (level != 0)`. `out_data` and `out_inv` are read from `rd_ptr`. There is no bypass: an empty FIFO never presents the word being written in the current cycle.
- `out_data` and `out_inv` are don't-care while `out_valid=0`, but must not be X after reset; storage is reset to 0.
- `inv_count` behaviour:
  - Increments by 1 on each push with `in_enum==ENUM1`.
  - Holds at all-ones once reached.
  - `clr_count` sets it to 0 and wins over a same-cycle increment.
- Handshake rules:
  - `in_valid` is ignored while `in_ready=0`; the upstream holds its word.
  - The block tolerates `out_ready` toggling freely, and `out_data` stays stable while `out_valid && !out_ready`.
- Reset values of all outputs:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_data` = 0.
  - `out_inv` = 0.
  - `level` = 0.
  - `inv_count` = 0.
  - Pointers and storage are also cleared.
- Reset mid-operation: all buffered words are discarded immediately (asynchronously). Outputs take their reset values while `rst_n=0`. Normal operation resumes on the first rising edge after deassertion.

## Timing

- Latency is 1 cycle: a word pushed at edge N is visible at the head with `out_valid=1` after edge N, provided the FIFO was empty.
- Throughput is 1 word per cycle sustained when `level` is between 1 and `DEPTH-1` and both sides are active.
- Full condition: with `level==DEPTH` and `out_ready=1`, the pop happens at edge N, `level` becomes `DEPTH-1`, and `in_ready` rises after edge N. The next push is no earlier than edge N+1.
- Empty condition: with `level==0`, `out_ready` has no effect and `level` cannot underflow.
- `inv_count` updates on the same edge as the push that it counts.

## Test plan

1. Reset: hold `rst_n=0` for 3 cycles, then release. Required: `in_ready=1`, `out_valid=0`, `level=0`, `inv_count=0`, `out_data=8'h00`.
2. Push `ENUM1` with `8'h3C`, `out_ready=1`. Required: the next cycle shows `out_valid=1`, `out_data=8'hC3`, `out_inv=1`, `inv_count=1`. Then push `ENUM2` with `8'hA5`. Required: `out_data=8'hA5`, `out_inv=0`, `inv_count` stays 1.
3. Hold `out_ready=0` and push 5 words `8'h01`..`8'h05` (all `ENUM2`). Required: `in_ready=0` after the 4th push, `level=4`, and word 5 is held upstream. Then drain with `out_ready=1`. Required: output order `01`, `02`, `03`, `04`, then `05`. Also exercise pointer wrap.
4. At `level=2`, push and pop simultaneously for 6 cycles. Required: `level` stays 2 and data stays in order across wrap.
5. With `CNT_W=2`, push 5 `ENUM1` words. Required: `inv_count` reads 1, 2, 3, 3, 3. Then assert `clr_count` in the same cycle as an `ENUM1` push. Required: `inv_count=0`.
6. At `level=3`, assert `rst_n=0` mid-cycle. Required: `out_valid=0` and `level=0` immediately, before the next edge. After release, a single push of `ENUM1` with `8'hFF` yields `out_data=8'h00`.
